// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master state encoding.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } axil_state_t;

endpackage

// File: rtl/axil_master_core_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axil_master_core_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] AWADDR;
   logic              AWVALID;
   logic              AWREADY;
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic              ARVALID;
   logic              ARREADY;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWADDR, AWVALID, input AWREADY,
      output WDATA, WSTRB, WVALID, input WREADY,
      input  BRESP, BVALID, output BREADY,
      output ARADDR, ARVALID, input ARREADY,
      input  RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input  AWADDR, AWVALID, output AWREADY,
      input  WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input  ARADDR, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface

// File: rtl/axil_vld_hold.sv
// One VALID/payload holding register for a single AXI request channel.
// VALID rises on load and falls the cycle after its handshake; the payload
// stays put until the next load. o_done reports "handshake has happened",
// including a handshake occurring in the current cycle.
module axil_vld_hold #(
   parameter int W = 32
) (
   input  logic         ACLK,
   input  logic         ARESETn,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_done
);
   logic         r_valid;
   logic         r_done;
   logic [W-1:0] r_data;
   logic         w_hs;

   assign w_hs    = r_valid & i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_done  = r_done | w_hs;

   // Load payload and raise VALID on a new command; retire VALID after handshake.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_done  <= 1'b0;
         r_data  <= i_data;
      end else if (w_hs) begin
         r_valid <= 1'b0;
         r_done  <= 1'b1;
      end
   end
endmodule

// File: rtl/axil_master_core.sv
// AXI4-Lite single-outstanding master: local command port in, local response
// port out. Optional response watchdog enabled by AXIL_MASTER_TIMEOUT_EN.
module axil_master_core
   import axil_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int STRB_W        = DATA_W / 8
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   axil_master_core_if.master  m_axi,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [STRB_W-1:0]   cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_write,
   output logic                rsp_timeout
);
   axil_state_t r_state, w_state_next;

   logic              r_cmd_write;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic [1:0]        r_rsp_resp;
   logic              r_rsp_write;
   logic              r_rsp_timeout;

   logic w_cmd_ready, w_cmd_accept, w_wr_load, w_rd_load;
   logic w_aw_done, w_w_done, w_ar_done;
   logic w_bready, w_rready, w_timeout_hit;
   logic [DATA_W+STRB_W-1:0] w_w_payload;

   // cmd_ready is held low while reset is asserted.
   assign w_cmd_ready  = (r_state == ST_IDLE) & ~ARESETn;
   assign w_cmd_accept = cmd_valid & w_cmd_ready;
   assign w_wr_load    = w_cmd_accept & cmd_write;
   assign w_rd_load    = w_cmd_accept & ~cmd_write;

   axil_vld_hold #(.W(ADDR_W)) u_aw (
      .ACLK(ACLK), .ARESETn(ARESETn), .i_load(w_wr_load), .i_data(cmd_addr),
      .i_ready(m_axi.AWREADY), .o_valid(m_axi.AWVALID), .o_data(m_axi.AWADDR),
      .o_done(w_aw_done)
   );

   axil_vld_hold #(.W(DATA_W + STRB_W)) u_w (
      .ACLK(ACLK), .ARESETn(ARESETn), .i_load(w_wr_load), .i_data({cmd_wstrb, cmd_wdata}),
      .i_ready(m_axi.WREADY), .o_valid(m_axi.WVALID), .o_data(w_w_payload),
      .o_done(w_w_done)
   );

   axil_vld_hold #(.W(ADDR_W)) u_ar (
      .ACLK(ACLK), .ARESETn(ARESETn), .i_load(w_rd_load), .i_data(cmd_addr),
      .i_ready(m_axi.ARREADY), .o_valid(m_axi.ARVALID), .o_data(m_axi.ARADDR),
      .o_done(w_ar_done)
   );

   assign m_axi.WDATA = w_w_payload[DATA_W-1:0];
   assign m_axi.WSTRB = w_w_payload[DATA_W+STRB_W-1:DATA_W];

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;
   logic             w_in_wait;

   assign w_in_wait     = (r_state == ST_WR_RESP) | (r_state == ST_RD_DATA);
   assign w_timeout_hit = w_in_wait & (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts cycles spent waiting for B/R, restarts on any state change.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         r_wait_cnt <= '0;
      end else if (w_state_next != r_state) begin
         r_wait_cnt <= '0;
      end else if (w_in_wait) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg  = (TIMEOUT_CYCLES == 0);
   assign w_timeout_hit = 1'b0;
`endif

   // BREADY/RREADY decode from state; with the watchdog, IDLE sinks late beats.
   always_comb begin
      w_bready = (r_state == ST_WR_RESP);
      w_rready = (r_state == ST_RD_DATA);
`ifdef AXIL_MASTER_TIMEOUT_EN
      if ((r_state == ST_IDLE) && !ARESETn) begin
         w_bready = 1'b1;
         w_rready = 1'b1;
      end
`endif
   end

   assign m_axi.BREADY = w_bready;
   assign m_axi.RREADY = w_rready;

   // State register.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_cmd_accept) w_state_next = cmd_write ? ST_WR_REQ : ST_RD_REQ;
         ST_WR_REQ:  if (w_aw_done && w_w_done) w_state_next = ST_WR_RESP;
         ST_WR_RESP: if (m_axi.BVALID || w_timeout_hit) w_state_next = ST_RSP;
         ST_RD_REQ:  if (w_ar_done) w_state_next = ST_RD_DATA;
         ST_RD_DATA: if (m_axi.RVALID || w_timeout_hit) w_state_next = ST_RSP;
         ST_RSP:     if (rsp_ready) w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // Capture transaction type on accept and the response payload on completion.
   always_ff @(posedge ACLK or posedge ARESETn) begin
      if (ARESETn) begin
         r_cmd_write   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= RESP_OKAY;
         r_rsp_write   <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_cmd_accept) r_cmd_write <= cmd_write;
         if ((r_state == ST_WR_RESP) && m_axi.BVALID) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= m_axi.BRESP;
            r_rsp_write   <= 1'b1;
            r_rsp_timeout <= 1'b0;
         end else if ((r_state == ST_RD_DATA) && m_axi.RVALID) begin
            r_rsp_rdata   <= m_axi.RDATA;
            r_rsp_resp    <= m_axi.RRESP;
            r_rsp_write   <= 1'b0;
            r_rsp_timeout <= 1'b0;
         end else if (w_timeout_hit) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_SLVERR;
            r_rsp_write   <= r_cmd_write;
            r_rsp_timeout <= 1'b1;
         end
      end
   end

   assign cmd_ready   = w_cmd_ready;
   assign rsp_valid   = (r_state == ST_RSP);
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;
   assign rsp_write   = r_rsp_write;
   assign rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_axil_master_core.sv
// Directed bench for axil_master_core; expected values are hand-computed.
module tb_axil_master_core;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   logic              ACLK = 1'b0;
   logic              ARESETn = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic [STRB_W-1:0] cmd_wstrb = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_resp;
   logic              rsp_write;
   logic              rsp_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   axil_master_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

   axil_master_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .m_axi(axi),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Present a command for one edge (caller is in an IDLE cycle).
   task automatic send_cmd(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_wdata = data; cmd_wstrb = strb;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
      axi.BVALID = 1'b0; axi.BRESP = 2'b00;
      axi.RVALID = 1'b0; axi.RRESP = 2'b00; axi.RDATA = '0;

      // ---- reset state ----
      tick(); tick();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_awvalid", axi.AWVALID, 0);
      chk("rst_arvalid", axi.ARVALID, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_awaddr", axi.AWADDR, 0);
      chk("rst_bready", axi.BREADY, 0);
      ARESETn = 1'b0;
      #1;
      chk("rel_cmd_ready", cmd_ready, 1);
`ifdef AXIL_MASTER_TIMEOUT_EN
      chk("idle_bready_sink", axi.BREADY, 1);
`else
      chk("idle_bready", axi.BREADY, 0);
`endif
      tick();

      // ---- write, zero-wait slave ----
      send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);           // edge N
      chk("w1_awvalid", axi.AWVALID, 1);                    // cycle N+1
      chk("w1_wvalid", axi.WVALID, 1);
      chk("w1_awaddr", axi.AWADDR, 64'h10);
      chk("w1_wdata", axi.WDATA, 64'hDEADBEEF);
      chk("w1_wstrb", axi.WSTRB, 4'hF);
      chk("w1_cmd_ready", cmd_ready, 0);
      axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
      tick();
      axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
      chk("w1_aw_drop", axi.AWVALID, 0);                    // cycle N+2
      chk("w1_w_drop", axi.WVALID, 0);
      chk("w1_bready", axi.BREADY, 1);
      axi.BVALID = 1'b1; axi.BRESP = 2'b00;
      tick();
      axi.BVALID = 1'b0;
      chk("w1_rsp_valid", rsp_valid, 1);                    // cycle N+3
      chk("w1_rsp_resp", rsp_resp, 2'b00);
      chk("w1_rsp_write", rsp_write, 1);
      chk("w1_rsp_rdata", rsp_rdata, 0);
      chk("w1_rsp_timeout", rsp_timeout, 0);
      $display("[TB] write addr=0x10 data=0xdeadbeef resp=%b", rsp_resp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("w1_back_idle", rsp_valid, 0);
      chk("w1_cmd_ready_again", cmd_ready, 1);

      // ---- write, AWREADY delayed, WREADY immediate ----
      send_cmd(1'b1, 32'h20, 32'hA5A5_0001, 4'h3);          // edge N
      axi.WREADY = 1'b1;                                    // cycle N+1
      tick();
      axi.WREADY = 1'b0;
      chk("w2_w_drop", axi.WVALID, 0);                      // cycle N+2
      chk("w2_aw_held", axi.AWVALID, 1);
      chk("w2_awaddr", axi.AWADDR, 64'h20);
      chk("w2_no_bready", axi.BREADY, 0);
      tick();
      chk("w2_aw_held2", axi.AWVALID, 1);                   // cycle N+3
      tick();
      chk("w2_awaddr2", axi.AWADDR, 64'h20);                // cycle N+4
      axi.AWREADY = 1'b1;
      tick();
      axi.AWREADY = 1'b0;
      chk("w2_aw_drop", axi.AWVALID, 0);
      chk("w2_bready", axi.BREADY, 1);
      axi.BVALID = 1'b1; axi.BRESP = 2'b01;
      tick();
      axi.BVALID = 1'b0;
      chk("w2_rsp_valid", rsp_valid, 1);
      chk("w2_one_b", axi.BREADY, 0);
      chk("w2_rsp_resp", rsp_resp, 2'b01);
      $display("[TB] write addr=0x20 delayed AW resp=%b", rsp_resp);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // ---- read with 2 wait cycles on R, SLVERR ----
      send_cmd(1'b0, 32'h4, 32'h0, 4'h0);                   // edge N
      chk("r1_arvalid", axi.ARVALID, 1);
      chk("r1_araddr", axi.ARADDR, 64'h4);
      chk("r1_no_aw", axi.AWVALID, 0);
      axi.ARREADY = 1'b1;
      tick();
      axi.ARREADY = 1'b0;
      chk("r1_ar_drop", axi.ARVALID, 0);
      chk("r1_rready", axi.RREADY, 1);
      tick();
      chk("r1_rready_wait", axi.RREADY, 1);
      chk("r1_no_rsp", rsp_valid, 0);
      tick();
      axi.RVALID = 1'b1; axi.RDATA = 32'h12345678; axi.RRESP = 2'b10;
      tick();
      axi.RVALID = 1'b0; axi.RDATA = '0;
      chk("r1_rsp_valid", rsp_valid, 1);
      chk("r1_rsp_rdata", rsp_rdata, 64'h12345678);
      chk("r1_rsp_resp", rsp_resp, 2'b10);
      chk("r1_rsp_write", rsp_write, 0);
      $display("[TB] read addr=0x4 data=0x%h resp=%b", rsp_rdata, rsp_resp);

      // ---- response back-pressure: hold rsp_ready low 5 cycles ----
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, 64'h12345678);
         chk("bp_rsp_resp", rsp_resp, 2'b10);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_no_aw", axi.AWVALID, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      $display("[TB] back-pressure 5 cycles, response held");

      // ---- reset mid WR_REQ ----
      send_cmd(1'b1, 32'h80, 32'h0BAD_F00D, 4'hF);
      chk("rm_awvalid", axi.AWVALID, 1);
      #2;
      ARESETn = 1'b1;
      #1;
      chk("rm_aw_async", axi.AWVALID, 0);
      chk("rm_w_async", axi.WVALID, 0);
      chk("rm_awaddr", axi.AWADDR, 0);
      tick();
      ARESETn = 1'b0;
      #1;
      chk("rm_cmd_ready", cmd_ready, 1);
      chk("rm_rsp_valid", rsp_valid, 0);
      tick();
      $display("[TB] reset during write request, recovered to idle");

`ifdef AXIL_MASTER_TIMEOUT_EN
      // ---- watchdog: B never arrives ----
      begin
         int busy_cycles = 0;
         int guard = 0;
         send_cmd(1'b1, 32'hC0, 32'h1, 4'h1);
         axi.AWREADY = 1'b1; axi.WREADY = 1'b1;
         tick();
         axi.AWREADY = 1'b0; axi.WREADY = 1'b0;
         while (!rsp_valid && guard < 50) begin
            if (axi.BREADY) busy_cycles++;
            tick();
            guard++;
         end
         chk("to_reached", (guard < 50), 1);
         chk("to_wait_cycles", busy_cycles, 8);
         chk("to_flag", rsp_timeout, 1);
         chk("to_resp", rsp_resp, 2'b10);
         chk("to_rdata", rsp_rdata, 0);
         chk("to_write", rsp_write, 1);
         $display("[TB] write addr=0xc0 timeout after %0d wait cycles", busy_cycles);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         chk("to_idle_bready", axi.BREADY, 1);
         axi.BVALID = 1'b1; axi.BRESP = 2'b00;
         tick();
         axi.BVALID = 1'b0;
         tick();
         chk("to_sunk_no_rsp", rsp_valid, 0);
         chk("to_sunk_cmd_ready", cmd_ready, 1);
         $display("[TB] stray B beat sunk in idle");
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL sim_timeout: got hang, expected completion");
      $fatal(1, "simulation time limit");
   end
endmodule
